// File: rtl/instr_prefetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_prefetch_unit_if
//   Bundles the program-memory read bus, the PM_* instruction handshake toward
//   the control unit, and the redirect request from the control unit.
//
//   master : the prefetch unit (drives mem_req/mem_addr and PM_data/PM_pc/PM_valid)
//   slave  : memory + control unit side (drives read data, PM_ready, redirect)
//
//   Signals
//     mem_req     prefetch -> memory   read request this cycle
//     mem_addr    prefetch -> memory   read address, valid with mem_req
//     mem_rdata   memory   -> prefetch read data, valid with mem_rvalid
//     mem_rvalid  memory   -> prefetch in-order response strobe
//     PM_data     prefetch -> control  head-of-queue instruction
//     PM_pc       prefetch -> control  address of PM_data
//     PM_valid    prefetch -> control  PM_data/PM_pc valid
//     PM_ready    control  -> prefetch head consumed when PM_valid && PM_ready
//     redirect    control  -> prefetch one-cycle PC discontinuity pulse
//     redirect_pc control  -> prefetch new fetch address, sampled with redirect
// ---------------------------------------------------------------------------
interface instr_prefetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) ();
  logic                   mem_req;
  logic [PC_WIDTH-1:0]    mem_addr;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   mem_rvalid;
  logic [INSTR_WIDTH-1:0] PM_data;
  logic [PC_WIDTH-1:0]    PM_pc;
  logic                   PM_valid;
  logic                   PM_ready;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_pc;

  modport master (
    output mem_req, mem_addr, PM_data, PM_pc, PM_valid,
    input  mem_rdata, mem_rvalid, PM_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, PM_data, PM_pc, PM_valid,
    output mem_rdata, mem_rvalid, PM_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// ---------------------------------------------------------------------------
// instr_prefetch_unit
//   Fetch stage in front of the control unit. Issues program-memory reads
//   ahead of execution under a credit scheme (queue occupancy + reads in
//   flight never exceeds DEPTH), tags each in-order response with its PC,
//   buffers it in a small FIFO and presents the head as PM_data/PM_pc with a
//   valid/ready handshake. A redirect pulse clears the queue, restarts
//   fetching at redirect_pc and drops every response still owed for the old
//   stream.
//
//   Ports
//     clock        rising-edge system clock
//     reset        asynchronous active-low reset
//     bus          instr_prefetch_unit_if.master (memory bus, PM handshake,
//                  redirect)
//     stat_flush   (PREFETCH_STATS_EN only) saturating count of redirects
//     stat_drop    (PREFETCH_STATS_EN only) saturating count of dropped responses
//     stat_stall   (PREFETCH_STATS_EN only) saturating count of cycles in FULL
//
//   Optional feature macro: PREFETCH_STATS_EN
// ---------------------------------------------------------------------------
module instr_prefetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  instr_prefetch_unit_if.master   bus
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]             stat_flush,
  output logic [15:0]             stat_drop,
  output logic [15:0]             stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;  // one extra bit distinguishes full from empty

  typedef enum logic [1:0] {FETCH, FULL, FLUSH} state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] data;
  } entry_t;

  entry_t                q_mem [DEPTH];
  entry_t                head;
  state_e                state_q, state_d;
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         inflight_q, inflight_d, discard_q, discard_d;
  logic [CW-1:0]         occ, occ_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]   rsp_pc_q, rsp_pc_d;  // PC owed to the next kept response
  logic                  issue, push, pop, drop;

  assign occ  = wr_ptr_q - rd_ptr_q;
  assign head = q_mem[rd_ptr_q[AW-1:0]];

  // reset gates the request combinationally so it drops the instant reset is
  // asserted; redirect gates it so no read of the stale stream is launched.
  assign issue = reset && !bus.redirect && (state_q != FULL) &&
                 ((occ + inflight_q) < CW'(DEPTH));

  // A response is stale while discards are owed, or if it lands on a redirect.
  assign drop = bus.mem_rvalid && (bus.redirect || (discard_q != '0));
  assign push = bus.mem_rvalid && !drop;
  assign pop  = bus.PM_valid && bus.PM_ready && !bus.redirect;

  assign bus.mem_req  = issue;
  assign bus.mem_addr = fetch_pc_q;
  assign bus.PM_valid = (occ != '0);
  // Zero when empty so the outputs have a defined value without resetting
  // the storage array.
  assign bus.PM_data  = bus.PM_valid ? head.data : '0;
  assign bus.PM_pc    = bus.PM_valid ? head.pc   : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d   = wr_ptr_q + CW'(push);
    rd_ptr_d   = rd_ptr_q + CW'(pop);
    inflight_d = inflight_q + CW'(issue) - CW'(bus.mem_rvalid);
    discard_d  = discard_q - CW'(drop);
    fetch_pc_d = fetch_pc_q + PC_WIDTH'(issue);
    rsp_pc_d   = rsp_pc_q + PC_WIDTH'(push);
    state_d    = state_q;

    if (bus.redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Everything still outstanding after this cycle's response is stale.
      discard_d  = inflight_q - CW'(bus.mem_rvalid);
      fetch_pc_d = bus.redirect_pc;
      rsp_pc_d   = bus.redirect_pc;
    end

    occ_d = wr_ptr_d - rd_ptr_d;

    if (discard_d != '0)                         state_d = FLUSH;
    else if ((occ_d + inflight_d) == CW'(DEPTH)) state_d = FULL;
    else                                         state_d = FETCH;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
    end
  end

  // NOTE: the queue storage has no reset; the pointers alone decide which
  // entries are live, so clearing the array would only cost flops.
  always_ff @(posedge clock) begin
    if (push) q_mem[wr_ptr_q[AW-1:0]] <= '{pc: rsp_pc_q, data: bus.mem_rdata};
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_flush_q, stat_drop_q, stat_stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_flush_q <= '0;
      stat_drop_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (bus.redirect && (stat_flush_q != 16'hFFFF)) stat_flush_q <= stat_flush_q + 16'd1;
      if (drop && (stat_drop_q != 16'hFFFF))          stat_drop_q  <= stat_drop_q + 16'd1;
      if ((state_q == FULL) && (stat_stall_q != 16'hFFFF))
        stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_flush = stat_flush_q;
  assign stat_drop  = stat_drop_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch_unit
//   Directed bench for instr_prefetch_unit with a program-memory model of
//   selectable fixed latency (1..3 cycles, in-order responses).
// ---------------------------------------------------------------------------
module tb_instr_prefetch_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat = 1;

  always #5 clock = ~clock;

  instr_prefetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_flush, stat_drop, stat_stall;
`endif

  instr_prefetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_flush (stat_flush),
    .stat_drop  (stat_drop),
    .stat_stall (stat_stall)
`endif
  );

  // Program contents: address 0 holds MOVI R3,#5, others {~addr, addr}.
  function automatic logic [15:0] memf(input logic [7:0] a);
    if (a == 8'h00) return 16'hA305;
    return {~a, a};
  endfunction

  // Memory model: request sampled at an edge, response valid lat cycles later.
  logic       pv [1:3];
  logic [7:0] pa [1:3];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= 3; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= 8'h00;
      end
    end else begin
      pv[1] <= bus.mem_req;
      pa[1] <= bus.mem_addr;
      for (int i = 2; i <= 3; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  assign bus.mem_rvalid = pv[lat];
  assign bus.mem_rdata  = memf(pa[lat]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 2 ns into the first cycle after reset release.
  task automatic do_reset(input int l);
    reset = 1'b0;
    cyc();
    lat = l;
    cyc();
    reset = 1'b1;
    #1;
  endtask

  int         nreq;
  logic [7:0] addrs [8];
  logic [7:0] pcs [4];
  logic [15:0] first_data;
  int         npc;
  logic       found;

  initial begin
    bus.PM_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;

    // ---------------- reset state ----------------
    cyc();
    cyc();
    check("rst_mem_req",  32'(bus.mem_req),  32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_pm_valid", 32'(bus.PM_valid), 32'h0);
    check("rst_pm_data",  32'(bus.PM_data),  32'h0);
    check("rst_pm_pc",    32'(bus.PM_pc),    32'h0);

    // ---------------- latency 1, PM_ready=1 ----------------
    // Release cycle counts as cycle 1.
    bus.PM_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("t1_c1_req",   32'(bus.mem_req),  32'h1);
    check("t1_c1_addr",  32'(bus.mem_addr), 32'h0);
    check("t1_c1_valid", 32'(bus.PM_valid), 32'h0);
    cyc();
    check("t1_c2_addr",  32'(bus.mem_addr), 32'h1);
    check("t1_c2_valid", 32'(bus.PM_valid), 32'h0);
    cyc();
    check("t1_c3_valid", 32'(bus.PM_valid), 32'h1);
    check("t1_c3_pc",    32'(bus.PM_pc),    32'h0);
    check("t1_c3_data",  32'(bus.PM_data),  32'hA305);
    check("t1_c3_addr",  32'(bus.mem_addr), 32'h2);
    cyc();
    check("t1_c4_pc",    32'(bus.PM_pc),    32'h1);
    check("t1_c4_data",  32'(bus.PM_data),  32'(memf(8'h01)));

    // ---------------- credit exhaustion, PM_ready=0 ----------------
    bus.PM_ready = 1'b0;
    do_reset(1);
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.mem_req) begin
        if (nreq < 8) addrs[nreq] = bus.mem_addr;
        nreq++;
      end
      cyc();
    end
    check("t2_nreq", 32'(nreq), 32'd4);
    for (int k = 0; k < 4; k++) check("t2_addr", 32'(addrs[k]), 32'(k));
    check("t2_full_req",  32'(bus.mem_req), 32'h0);
    check("t2_hold_pc",   32'(bus.PM_pc),   32'h0);
    check("t2_hold_data", 32'(bus.PM_data), 32'hA305);
    bus.PM_ready = 1'b1;
    #1;
    check("t2_pop_req", 32'(bus.mem_req), 32'h0);
    cyc();
    bus.PM_ready = 1'b0;
    #1;
    check("t2_new_req",  32'(bus.mem_req),  32'h1);
    check("t2_new_addr", 32'(bus.mem_addr), 32'h4);
    nreq = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.mem_req) nreq++;
      cyc();
    end
    check("t2_one_req", 32'(nreq), 32'd1);
    check("t2_head_pc", 32'(bus.PM_pc), 32'h1);

    // ---------------- latency 3, redirect to 0x40 ----------------
    bus.PM_ready = 1'b0;
    do_reset(3);
    cyc();
    cyc();
    cyc();
    // Requests 0,1,2 outstanding; response for 0 arrives this very cycle.
    check("t3_rvalid_at_redirect", 32'(bus.mem_rvalid), 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    cyc();
    bus.redirect = 1'b0;
    #1;
    check("t3_valid_after", 32'(bus.PM_valid), 32'h0);
    check("t3_req_new",     32'(bus.mem_req),  32'h1);
    check("t3_addr_new",    32'(bus.mem_addr), 32'h40);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (bus.PM_valid) found = 1'b1;
      else cyc();
    end
    check("t3_wait_valid", 32'(found), 32'h1);
    check("t3_first_pc",   32'(bus.PM_pc),   32'h40);
    check("t3_first_data", 32'(bus.PM_data), 32'(memf(8'h40)));

    // ------- redirect + response + pop in one cycle, to 0xFE (wrap) -------
    check("t5_rvalid_same_cycle", 32'(bus.mem_rvalid), 32'h1);
    bus.PM_ready    = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFE;
    cyc();
    bus.redirect = 1'b0;
    #1;
    check("t5_valid_next", 32'(bus.PM_valid), 32'h0);
    npc = 0;
    first_data = 16'h0;
    for (int k = 0; k < 24 && npc < 4; k++) begin
      if (bus.PM_valid) begin
        if (npc == 0) first_data = bus.PM_data;
        pcs[npc] = bus.PM_pc;
        npc++;
      end
      cyc();
    end
    check("t4_npc", 32'(npc), 32'd4);
    check("t4_pc0", 32'(pcs[0]), 32'hFE);
    check("t4_pc1", 32'(pcs[1]), 32'hFF);
    check("t4_pc2", 32'(pcs[2]), 32'h00);
    check("t4_pc3", 32'(pcs[3]), 32'h01);
    check("t4_data0", 32'(first_data), 32'(memf(8'hFE)));

    // ---------------- async reset mid-stream ----------------
    bus.PM_ready = 1'b0;
    do_reset(1);
    cyc();
    cyc();
    cyc();
    check("t6_pre_valid", 32'(bus.PM_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.PM_valid), 32'h0);
    check("t6_async_req",   32'(bus.mem_req),  32'h0);
    check("t6_async_data",  32'(bus.PM_data),  32'h0);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("t6_restart_req",  32'(bus.mem_req),  32'h1);
    check("t6_restart_addr", 32'(bus.mem_addr), 32'h0);
    bus.PM_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (bus.PM_valid) found = 1'b1;
      else cyc();
    end
    check("t6_wait_valid", 32'(found), 32'h1);
    check("t6_pc",   32'(bus.PM_pc),   32'h0);
    check("t6_data", 32'(bus.PM_data), 32'hA305);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
